// File: rtl/signal_shifter_pkg.sv
`default_nettype none
// signal_shifter_pkg: shared types and default limits for the signal-shifter sequencer.
package signal_shifter_pkg;

    localparam int unsigned DEF_MAX_DELAY   = 10000000;
    localparam int unsigned DEF_MAX_EVENT   = 10;
    localparam int unsigned DEF_DELAY_WIDTH = $clog2(DEF_MAX_DELAY);
    localparam int unsigned DEF_EVENT_WIDTH = $clog2(DEF_MAX_EVENT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_NEXT = 2'd3
    } seq_state_t;

    // "event" is a reserved word, hence event_cnt
    typedef struct packed {
        logic [DEF_DELAY_WIDTH-1:0] delay;
        logic [DEF_EVENT_WIDTH-1:0] event_cnt;
        logic                       polarity;
    } shift_entry_t;

endpackage
`default_nettype wire

// File: rtl/signal_shifter_sequencer_cfg_table.sv
`default_nettype none
// shift_cfg_table: DEPTH-entry trigger configuration register file with append pointer,
// full flag and asynchronous read port. Contents are not reset; the count is.
module shift_cfg_table #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PTR_WIDTH   = $clog2(DEPTH),
    parameter int unsigned DELAY_WIDTH = 24,
    parameter int unsigned EVENT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic                   clear_i,
    input  logic [DELAY_WIDTH-1:0] wr_delay_i,
    input  logic [EVENT_WIDTH-1:0] wr_event_i,
    input  logic                   wr_pol_i,
    input  logic [PTR_WIDTH-1:0]   rd_idx_i,
    output logic [DELAY_WIDTH-1:0] rd_delay_o,
    output logic [EVENT_WIDTH-1:0] rd_event_o,
    output logic                   rd_pol_o,
    output logic [PTR_WIDTH:0]     count_o,
    output logic                   full_o
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = DEPTH[PTR_WIDTH:0];

    typedef struct packed {
        logic [DELAY_WIDTH-1:0] delay;
        logic [EVENT_WIDTH-1:0] event_cnt;
        logic                   polarity;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [PTR_WIDTH:0]   count_q;
    logic [PTR_WIDTH:0]   count_d;
    logic                 full_q;
    logic                 wr_accept;

    assign wr_accept = wr_en_i && !clear_i && !full_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wr_accept) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[count_q[PTR_WIDTH-1:0]] <= '{delay: wr_delay_i, event_cnt: wr_event_i, polarity: wr_pol_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
        end
    end

    assign rd_delay_o = mem_q[rd_idx_i].delay;
    assign rd_event_o = mem_q[rd_idx_i].event_cnt;
    assign rd_pol_o   = mem_q[rd_idx_i].polarity;
    assign count_o    = count_q;
    assign full_o     = full_q;

endmodule
`default_nettype wire

// File: rtl/signal_shifter_sequencer.sv
`default_nettype none
// signal_shifter_sequencer: steps one shifter channel through a table of trigger settings.
// Optional WAIT watchdog enabled by defining SHIFTER_SEQ_TIMEOUT_EN.
module signal_shifter_sequencer
    import signal_shifter_pkg::*;
#(
    parameter int unsigned MAX_DELAY      = DEF_MAX_DELAY,
    parameter int unsigned MAX_EVENT      = DEF_MAX_EVENT,
    parameter int unsigned DELAY_WIDTH    = $clog2(MAX_DELAY),
    parameter int unsigned EVENT_WIDTH    = $clog2(MAX_EVENT),
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned PTR_WIDTH      = $clog2(DEPTH),
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr_en_i,
    input  logic [DELAY_WIDTH-1:0] cfg_delay_i,
    input  logic [EVENT_WIDTH-1:0] cfg_event_i,
    input  logic                   cfg_polarity_i,
    input  logic                   cfg_clear_i,
    output logic                   cfg_full_o,
    output logic [PTR_WIDTH:0]     cfg_count_o,
    output logic                   cfg_err_o,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   loop_en_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [PTR_WIDTH-1:0]   step_index_o,
    output logic [DELAY_WIDTH-1:0] sh_delay_value_o,
    output logic                   sh_delay_set_o,
    output logic [EVENT_WIDTH-1:0] sh_event_value_o,
    output logic                   sh_event_set_o,
    output logic                   sh_polarity_o,
    output logic                   sh_auto_start_o,
    input  logic                   sh_output_i,
    output logic                   timeout_o
);

    seq_state_t             state_q, state_d;
    logic [PTR_WIDTH-1:0]   step_q, step_d;
    logic [PTR_WIDTH:0]     count;
    logic                   full;
    logic                   is_idle;
    logic                   last_entry;
    logic                   wdog_expire;
    logic                   tbl_wr_en;
    logic                   tbl_clear;
    logic [DELAY_WIDTH-1:0] rd_delay;
    logic [EVENT_WIDTH-1:0] rd_event;
    logic                   rd_pol;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   load_q, load_d;
    logic                   auto_q, auto_d;
    logic [DELAY_WIDTH-1:0] dval_q, dval_d;
    logic [EVENT_WIDTH-1:0] eval_q, eval_d;
    logic                   pol_q, pol_d;

    assign is_idle    = (state_q == ST_IDLE);
    assign last_entry = ({1'b0, step_q} == (count - 1'b1));
    // a simultaneous clear swallows the write silently
    assign tbl_wr_en  = cfg_wr_en_i && !cfg_clear_i && is_idle && !full;
    assign tbl_clear  = cfg_clear_i && is_idle;

    // Read at the index being entered so the outputs register alongside the load strobes
    shift_cfg_table #(
        .DEPTH       (DEPTH),
        .PTR_WIDTH   (PTR_WIDTH),
        .DELAY_WIDTH (DELAY_WIDTH),
        .EVENT_WIDTH (EVENT_WIDTH)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (tbl_wr_en),
        .clear_i    (tbl_clear),
        .wr_delay_i (cfg_delay_i),
        .wr_event_i (cfg_event_i),
        .wr_pol_i   (cfg_polarity_i),
        .rd_idx_i   (step_d),
        .rd_delay_o (rd_delay),
        .rd_event_o (rd_event),
        .rd_pol_o   (rd_pol),
        .count_o    (count),
        .full_o     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            auto_q  <= 1'b0;
            dval_q  <= '0;
            eval_q  <= '0;
            pol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            load_q  <= load_d;
            auto_q  <= auto_d;
            dval_q  <= dval_d;
            eval_q  <= eval_d;
            pol_q   <= pol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && (count != '0)) begin
                        state_d = ST_LOAD;
                        step_d  = '0;
                    end
                end
                ST_LOAD: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (sh_output_i) begin
                        state_d = ST_NEXT;
                    end else if (wdog_expire) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    if (!last_entry) begin
                        step_d  = step_q + 1'b1;
                        state_d = ST_LOAD;
                    end else if (loop_en_i) begin
                        step_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d != ST_IDLE);
        load_d = (state_d == ST_LOAD);
        auto_d = (state_d == ST_WAIT);
        done_d = !stop_i && (state_q == ST_NEXT) && last_entry && !loop_en_i;
        err_d  = (!stop_i && is_idle && start_i && (count == '0))
               || (cfg_wr_en_i && !cfg_clear_i && (!is_idle || full))
               || (cfg_clear_i && !is_idle);
        dval_d = load_d ? rd_delay : dval_q;
        eval_d = load_d ? rd_event : eval_q;
        pol_d  = load_d ? rd_pol   : pol_q;
    end

`ifdef SHIFTER_SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_WIDTH = DELAY_WIDTH + 8;

    logic [WDOG_WIDTH-1:0] wdog_q;
    logic                  timeout_q;

    // Restarts on every entry to WAIT because it is held at zero outside WAIT
    always_ff @(posedge clk) begin
        if (reset || (state_q != ST_WAIT)) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign wdog_expire = (state_q == ST_WAIT) && (wdog_q == WDOG_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= !stop_i && !sh_output_i && wdog_expire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wdog_expire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    assign cfg_full_o       = full;
    assign cfg_count_o      = count;
    assign cfg_err_o        = err_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign step_index_o     = step_q;
    assign sh_delay_value_o = dval_q;
    assign sh_delay_set_o   = load_q;
    assign sh_event_value_o = eval_q;
    assign sh_event_set_o   = load_q;
    assign sh_polarity_o    = pol_q;
    assign sh_auto_start_o  = auto_q;

endmodule
`default_nettype wire

// File: tb/tb_signal_shifter_sequencer.sv
`default_nettype none
// tb_signal_shifter_sequencer: directed/randomized bench with a queue-based table model.
module tb_signal_shifter_sequencer;
    import signal_shifter_pkg::*;

    localparam int unsigned DW    = DEF_DELAY_WIDTH;
    localparam int unsigned EW    = DEF_EVENT_WIDTH;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_wr_en_i = 1'b0;
    logic [DW-1:0] cfg_delay_i = '0;
    logic [EW-1:0] cfg_event_i = '0;
    logic          cfg_polarity_i = 1'b0;
    logic          cfg_clear_i = 1'b0;
    logic          cfg_full_o;
    logic [PW:0]   cfg_count_o;
    logic          cfg_err_o;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          loop_en_i = 1'b0;
    logic          busy_o, done_o;
    logic [PW-1:0] step_index_o;
    logic [DW-1:0] sh_delay_value_o;
    logic          sh_delay_set_o;
    logic [EW-1:0] sh_event_value_o;
    logic          sh_event_set_o, sh_polarity_o, sh_auto_start_o;
    logic          sh_output_i = 1'b0;
    logic          timeout_o;

    int errors = 0;
    int checks = 0;
    shift_entry_t model_q[$];

    signal_shifter_sequencer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_wr_en_i      (cfg_wr_en_i),
        .cfg_delay_i      (cfg_delay_i),
        .cfg_event_i      (cfg_event_i),
        .cfg_polarity_i   (cfg_polarity_i),
        .cfg_clear_i      (cfg_clear_i),
        .cfg_full_o       (cfg_full_o),
        .cfg_count_o      (cfg_count_o),
        .cfg_err_o        (cfg_err_o),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .loop_en_i        (loop_en_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .step_index_o     (step_index_o),
        .sh_delay_value_o (sh_delay_value_o),
        .sh_delay_set_o   (sh_delay_set_o),
        .sh_event_value_o (sh_event_value_o),
        .sh_event_set_o   (sh_event_set_o),
        .sh_polarity_o    (sh_polarity_o),
        .sh_auto_start_o  (sh_auto_start_o),
        .sh_output_i      (sh_output_i),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, cfg_err_o, 0);
        chk({tag, "_full"}, cfg_full_o, 0);
        chk({tag, "_count"}, cfg_count_o, 0);
        chk({tag, "_step"}, step_index_o, 0);
        chk({tag, "_dval"}, sh_delay_value_o, 0);
        chk({tag, "_dset"}, sh_delay_set_o, 0);
        chk({tag, "_eval"}, sh_event_value_o, 0);
        chk({tag, "_eset"}, sh_event_set_o, 0);
        chk({tag, "_pol"}, sh_polarity_o, 0);
        chk({tag, "_auto"}, sh_auto_start_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
    endtask

    task automatic write_entry(input shift_entry_t e);
        bit acc;
        acc = (model_q.size() < DEPTH);
        cfg_delay_i    = e.delay;
        cfg_event_i    = e.event_cnt;
        cfg_polarity_i = e.polarity;
        cfg_wr_en_i    = 1'b1;
        tick();
        cfg_wr_en_i    = 1'b0;
        if (acc) model_q.push_back(e);
        chk("wr_err", cfg_err_o, !acc);
        chk("wr_count", cfg_count_o, model_q.size());
        chk("wr_full", cfg_full_o, model_q.size() == DEPTH);
    endtask

    task automatic clear_table();
        cfg_clear_i = 1'b1;
        tick();
        cfg_clear_i = 1'b0;
        model_q.delete();
        chk("clr_count", cfg_count_o, 0);
        chk("clr_err", cfg_err_o, 0);
    endtask

    function automatic shift_entry_t rand_entry();
        shift_entry_t e;
        e.delay     = DW'($urandom_range(0, DEF_MAX_DELAY));
        e.event_cnt = EW'($urandom_range(0, DEF_MAX_EVENT));
        e.polarity  = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic chk_load(input int idx);
        chk("load_step", step_index_o, idx);
        chk("load_dset", sh_delay_set_o, 1);
        chk("load_eset", sh_event_set_o, 1);
        chk("load_dval", sh_delay_value_o, model_q[idx].delay);
        chk("load_eval", sh_event_value_o, model_q[idx].event_cnt);
        chk("load_pol", sh_polarity_o, model_q[idx].polarity);
        chk("load_auto", sh_auto_start_o, 0);
        chk("load_busy", busy_o, 1);
    endtask

    // Entry k of a run uses table[k mod n]; each output pulse leads to the next load two cycles later.
    task automatic play(input bit loop, input int pulses);
        int n;
        int w;
        n = model_q.size();
        loop_en_i = loop;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < pulses; k++) begin
            chk_load(k % n);
            tick();
            chk("wait_auto", sh_auto_start_o, 1);
            chk("wait_dset", sh_delay_set_o, 0);
            w = $urandom_range(0, 3);
            for (int j = 0; j < w; j++) begin
                tick();
                chk("hold_auto", sh_auto_start_o, 1);
                chk("hold_done", done_o, 0);
            end
            sh_output_i = 1'b1;
            tick();
            sh_output_i = 1'b0;
            chk("next_auto", sh_auto_start_o, 0);
            chk("next_busy", busy_o, 1);
            chk("next_done", done_o, 0);
            tick();
        end
        if (!loop) begin
            chk("end_done", done_o, 1);
            chk("end_busy", busy_o, 0);
            chk("end_pol_hold", sh_polarity_o, model_q[n-1].polarity);
            chk("end_dval_hold", sh_delay_value_o, model_q[n-1].delay);
            tick();
            chk("end_done_pulse", done_o, 0);
        end else begin
            chk_load(pulses % n);
            tick();
            chk("loop_auto", sh_auto_start_o, 1);
            stop_i = 1'b1;
            tick();
            stop_i = 1'b0;
            chk("stop_busy", busy_o, 0);
            chk("stop_auto", sh_auto_start_o, 0);
            chk("stop_done", done_o, 0);
            tick();
            chk("stop_done2", done_o, 0);
        end
        loop_en_i = 1'b0;
    endtask

    initial begin
        shift_entry_t e;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_state("rst");

        // three-entry one-shot run
        e = '{delay: DW'(5), event_cnt: EW'(2), polarity: 1'b0}; write_entry(e);
        e = '{delay: DW'(3), event_cnt: EW'(1), polarity: 1'b1}; write_entry(e);
        e = '{delay: DW'(1), event_cnt: EW'(0), polarity: 1'b0}; write_entry(e);
        play(1'b0, 3);

        // looped run over two random entries
        clear_table();
        write_entry(rand_entry());
        write_entry(rand_entry());
        play(1'b1, 5);

        // fill past capacity
        clear_table();
        for (int i = 0; i < 9; i++) write_entry(rand_entry());
        tick();
        chk("full_err_clears", cfg_err_o, 0);
        play(1'b0, 8);

        // clear and write together: clear wins silently
        cfg_clear_i = 1'b1;
        cfg_wr_en_i = 1'b1;
        tick();
        cfg_clear_i = 1'b0;
        cfg_wr_en_i = 1'b0;
        model_q.delete();
        chk("clrwr_count", cfg_count_o, 0);
        chk("clrwr_err", cfg_err_o, 0);

        // start with empty table
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("empty_err", cfg_err_o, 1);
        chk("empty_busy", busy_o, 0);
        tick();
        chk("empty_err_pulse", cfg_err_o, 0);
        chk("empty_busy2", busy_o, 0);

        // writes and clears rejected during playback, then reset in WAIT
        write_entry(rand_entry());
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("busy_wait_auto", sh_auto_start_o, 1);
        cfg_delay_i = DW'(7);
        cfg_wr_en_i = 1'b1;
        tick();
        cfg_wr_en_i = 1'b0;
        chk("busy_wr_err", cfg_err_o, 1);
        chk("busy_wr_count", cfg_count_o, 1);
        cfg_clear_i = 1'b1;
        tick();
        cfg_clear_i = 1'b0;
        chk("busy_clr_err", cfg_err_o, 1);
        chk("busy_clr_count", cfg_count_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_q.delete();
        chk_reset_state("midrst");

        // watchdog behaviour on a shifter that never fires
        write_entry(rand_entry());
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk_load(0);
        tick();
`ifdef SHIFTER_SEQ_TIMEOUT_EN
        for (int j = 1; j < 16; j++) begin
            tick();
            chk("wd_auto", sh_auto_start_o, 1);
            chk("wd_timeout", timeout_o, 0);
        end
        tick();
        chk("wd_fire", timeout_o, 1);
        chk("wd_busy", busy_o, 0);
        chk("wd_auto_drop", sh_auto_start_o, 0);
        chk("wd_done", done_o, 0);
        tick();
        chk("wd_pulse", timeout_o, 0);
        chk("wd_done2", done_o, 0);
`else
        for (int j = 0; j < 20; j++) tick();
        chk("nowd_busy", busy_o, 1);
        chk("nowd_auto", sh_auto_start_o, 1);
        chk("nowd_timeout", timeout_o, 0);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("nowd_stop", busy_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signal_shifter_sequencer.md
# signal_shifter_sequencer

Programs and sequences one signal-shifter channel through a small table of trigger configurations: event count, delay and edge polarity. For each entry it loads the channel's delay and event registers, arms the channel, and waits for the channel's output pulse before stepping to the next entry. It sits between the PS-side register interface and the shifter channel in the IOController. It supports one-shot or looped playback.

## Interface
Parameters:
- MAX_DELAY, 10000000, largest programmable delay in clk cycles
- MAX_EVENT, 10, largest programmable event count
- DELAY_WIDTH, $clog2(MAX_DELAY), delay field width
- EVENT_WIDTH, $clog2(MAX_EVENT), event field width
- DEPTH, 8, table entries; power of two
- PTR_WIDTH, $clog2(DEPTH), table index width
- TIMEOUT_CYCLES, 2**24, watchdog limit (used only with SHIFTER_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_wr_en  in  1  append one entry to the table
- cfg_delay  in  DELAY_WIDTH  entry delay
- cfg_event  in  EVENT_WIDTH  entry event count
- cfg_polarity  in  1  entry edge polarity (1 = falling, 0 = rising)
- cfg_clear  in  1  empty the table
- cfg_full  out  1  table holds DEPTH entries
- cfg_count  out  PTR_WIDTH+1  number of valid entries
- cfg_err  out  1  one-cycle pulse on a rejected write or clear
- start  in  1  begin playback at entry 0
- stop  in  1  abort playback
- loop_en  in  1  restart at entry 0 after the last entry
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last entry completes (loop_en low)
- step_index  out  PTR_WIDTH  index of the entry currently in use
- sh_delay_value  out  DELAY_WIDTH  to the shifter's delay value input
- sh_delay_set  out  1  to the shifter's delay load strobe
- sh_event_value  out  EVENT_WIDTH  to the shifter's event value input
- sh_event_set  out  1  to the shifter's event load strobe
- sh_polarity  out  1  to the shifter's polarity input
- sh_auto_start  out  1  shifter enable
- sh_output  in  1  shifter output pulse
- timeout  out  1  watchdog pulse

## Operation
- States: IDLE, LOAD, WAIT, NEXT.
- IDLE: when start=1 and cfg_count>0, clear step_index and go to LOAD. When start=1 and cfg_count=0, stay in IDLE and pulse cfg_err.
- LOAD: drive sh_delay_value, sh_event_value and sh_polarity from table[step_index]. Assert sh_delay_set and sh_event_set for exactly this one cycle. Go to WAIT.
- WAIT: hold sh_auto_start=1. When sh_output=1, go to NEXT.
- NEXT: sh_auto_start=0.
  - If step_index is not the last entry (cfg_count-1): increment step_index and go to LOAD.
  - At the last entry with loop_en=1: set step_index to 0 and go to LOAD.
  - At the last entry with loop_en=0: pulse done and go to IDLE.
- stop=1 in any state forces IDLE on the next edge; done does not pulse. stop takes priority over start and over sh_output.
- Table writes:
  - Accepted only in IDLE, and only while cfg_full=0.
  - A write that is not accepted is dropped and pulses cfg_err.
  - An accepted write stores the entry at index cfg_count and increments cfg_count.
- cfg_clear in IDLE sets cfg_count to 0. Outside IDLE it is ignored and pulses cfg_err. If cfg_clear and cfg_wr_en arrive in the same cycle, the clear wins and the write is dropped without cfg_err.
- Table contents survive reset; cfg_count does not.
- sh_polarity holds its last loaded value between entries.

## Timing
- Reset values: busy=0, done=0, cfg_err=0, cfg_full=0, cfg_count=0, step_index=0, all sh_* outputs 0, timeout=0. Reset mid-playback returns to IDLE on that edge.
- start sampled in IDLE → LOAD strobes on the next cycle → sh_auto_start rises the cycle after that.
- sh_output seen in WAIT → next entry's load strobes appear 2 cycles later (via NEXT).
- After the last entry, done is registered and appears 1 cycle after NEXT.
- All outputs are registered.
- sh_auto_start is low during LOAD, so the shifter never runs with a half-loaded configuration.

## Configuration
- SHIFTER_SEQ_TIMEOUT_EN defined:
  - A DELAY_WIDTH+8-bit watchdog counts cycles in WAIT and clears on every entry to WAIT.
  - When it reaches TIMEOUT_CYCLES: pulse timeout for one cycle, drop sh_auto_start and go to IDLE. done does not pulse.
- SHIFTER_SEQ_TIMEOUT_EN not defined: no watchdog logic; timeout is tied to 0; WAIT lasts indefinitely.

## Structure
- Shared package signal_shifter_pkg holds:
  - the state enum seq_state_t;
  - the packed entry struct shift_entry_t {delay, event, polarity};
  - the default MAX_DELAY/MAX_EVENT constants.
- One sub-module, shift_cfg_table: DEPTH×entry register file with the write pointer/count, a full flag, and an asynchronous read at step_index.

## Test plan
- Write 3 entries {event 2, delay 5, pol 0}, {1, 3, 1}, {0, 1, 0}; start; model the shifter response → three LOAD strobe pairs carrying those values in order, step_index 0→1→2, done one cycle after the third sh_output, busy=0 afterwards.
- loop_en=1 with 2 entries; feed 5 sh_output pulses → step_index 0,1,0,1,0,1; no done; stop → IDLE next cycle with sh_auto_start=0.
- Write 9 entries with DEPTH=8 → cfg_full=1 after the 8th; the 9th pulses cfg_err; cfg_count=8.
- start with an empty table → cfg_err pulse, busy stays 0. cfg_wr_en during WAIT → cfg_err, cfg_count unchanged.
- Reset asserted in WAIT → all outputs at reset values next cycle; cfg_count=0.
- With SHIFTER_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: no sh_output → timeout pulse after 16 WAIT cycles, IDLE, done stays 0.
